// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring DIV/DIVU, {remainder, quotient} out, stall request while busy
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
  state_t state, state_n;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] rem, dvd, dvs, rem_n, quo_n, a1, a2;
  logic [WIDTH:0] shifted, trial;
  logic neg1, neg2, last;
  always_comb begin
    a1 = (signed_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    a2 = (signed_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    shifted = {rem, dvd[WIDTH-1]};
    trial = shifted - {1'b0, dvs};
    rem_n = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_n = {dvd[WIDTH-2:0], ~trial[WIDTH]};
    last = count == CW'(WIDTH - 1);
    state_n = annul_i ? IDLE :
              state == IDLE ? (start_i ? (opdata2_i == '0 ? BYZERO : ON) : IDLE) :
              state == BYZERO ? END :
              state == ON ? (last ? END : ON) : IDLE;
    stallreq_o = start_i & ~ready_o & ~annul_i;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst || annul_i) begin
      count <= '0;
      result_o <= '0;
      ready_o <= 1'b0;
    end else begin
      ready_o <= (state == BYZERO) || (state == ON && last);
      if (state == IDLE && start_i) begin
        rem <= '0;
        dvd <= a1;
        dvs <= a2;
        count <= '0;
        neg1 <= signed_i & opdata1_i[WIDTH-1];
        neg2 <= signed_i & opdata2_i[WIDTH-1];
      end
      if (state == BYZERO) result_o <= '0;
      if (state == ON) begin
        rem <= rem_n;
        dvd <= quo_n;
        count <= count + 1'b1;
        if (last) result_o <= {neg1 ? -rem_n : rem_n, (neg1 ^ neg2) ? -quo_n : quo_n};
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table, random and corner-sequence checks of div_unit against an arithmetic model
module tb_div_unit;
  localparam int WIDTH = 32;
  logic clk = 0, rst = 1, start_i = 0, signed_i = 0, annul_i = 0;
  logic [WIDTH-1:0] opdata1_i = '0, opdata2_i = '0;
  logic [2*WIDTH-1:0] result_o;
  logic ready_o, stallreq_o;
  int vectors = 0, miscompares = 0;
  time last_ready;
  div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic s;
    logic [31:0] a, b;
    logic [63:0] r;
  } vec_t;
  vec_t tbl[9];
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return '0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  // Call just after a falling edge with the DUT idle; returns at the falling edge of the ready cycle.
  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input bit keep, input string name);
    int t, lat;
    bit stall_ok;
    lat = (b == 0) ? 2 : WIDTH + 1;
    signed_i = s; opdata1_i = a; opdata2_i = b; start_i = 1; stall_ok = 1;
    #1;
    t = 0;
    while (!ready_o && t < 60) begin
      if (!stallreq_o) stall_ok = 0;
      @(negedge clk);
      t++;
      signed_i = 1'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
    end
    last_ready = $time;
    check({name, " latency"}, 64'(t), 64'(lat));
    check({name, " result"}, result_o, exp);
    check({name, " stallreq"}, {63'b0, stall_ok & ~stallreq_o}, 64'd1);
    signed_i = 0;
    if (!keep) start_i = 0;
  endtask
  task automatic count_ready(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o) n++;
    end
  endtask
  initial begin
    logic s;
    logic [31:0] a, b;
    int n;
    time t1;
    tbl[0] = '{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}};
    tbl[1] = '{1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    tbl[2] = '{1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}};
    tbl[3] = '{1'b1, 32'd1234, 32'd0, 64'd0};
    tbl[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}};
    tbl[5] = '{1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}};
    tbl[6] = '{1'b0, 32'd5, 32'd9, {32'd5, 32'd0}};
    tbl[7] = '{1'b1, -32'sd8, -32'sd3, {32'hFFFF_FFFE, 32'd2}};
    tbl[8] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}};
    repeat (3) @(negedge clk);
    check("reset ready", {63'b0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    check("reset stallreq", {63'b0, stallreq_o}, 64'd0);
    rst = 0;
    @(negedge clk);
    foreach (tbl[i]) begin
      run(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].r, 0, $sformatf("tbl%0d", i));
      @(negedge clk);
    end
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom);
      a = $urandom;
      b = (k % 8 == 0) ? 32'd0 : (k % 3 == 0) ? $urandom_range(1, 15) : $urandom;
      if (k % 5 == 0) b = -b;
      run(s, a, b, model(s, a, b), 0, $sformatf("rnd%0d", k));
      @(negedge clk);
    end
    run(0, 32'd20, 32'd3, {32'd2, 32'd6}, 1, "b2b first");
    t1 = last_ready;
    opdata1_i = 32'd9; opdata2_i = 32'd4;
    @(negedge clk);
    run(0, 32'd9, 32'd4, {32'd1, 32'd2}, 0, "b2b second");
    check("b2b spacing", 64'(last_ready - t1), 64'd340);
    @(negedge clk);
    signed_i = 0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1;
    repeat (10) @(negedge clk);
    annul_i = 1;
    #1 check("annul stallreq", {63'b0, stallreq_o}, 64'd0);
    @(negedge clk);
    annul_i = 0; start_i = 0;
    #1 check("annul stall drop", {63'b0, stallreq_o}, 64'd0);
    count_ready(40, n);
    check("annul no ready", 64'(n), 64'd0);
    check("annul result", result_o, 64'd0);
    run(0, 32'd77, 32'd10, {32'd7, 32'd7}, 0, "after annul");
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1;
    repeat (5) @(negedge clk);
    rst = 1; start_i = 0;
    @(negedge clk);
    rst = 0;
    count_ready(40, n);
    check("rst no ready", 64'(n), 64'd0);
    check("rst result", result_o, 64'd0);
    run(1, -32'sd100, 32'd7, model(1, -32'sd100, 32'd7), 0, "after rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
